// File: rtl/integ_sched.sv
// Round-robin integrator: NCH channel accumulators share one signed W-bit adder (IDLE/ADD/WB).
// Define INTEG_SCHED_SAT_EN to clamp on signed overflow and expose sticky sat flags; default wraps.
module integ_sched #(
   parameter int NCH = 3,
   parameter int W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [NCH-1:0]   req,
   input  logic [NCH*W-1:0] data,
   input  logic [NCH-1:0]   clear,
   output logic [NCH-1:0]   ack,
   output logic [NCH*W-1:0] sum,
   output logic [NCH-1:0]   sat,
   output logic             busy
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, ADD, WB} state_t;

   state_t        state;
   state_t        state_next;
   logic [IW-1:0] last;
   logic [IW-1:0] grant;
   logic [IW-1:0] gsel;
   logic          grant_valid;
   logic [W-1:0]  operand;
   logic [W-1:0]  sum_next;
   logic [W-1:0]  result;
   logic [W-1:0]  wb_value;
   logic [W-1:0]  acc [NCH];

   // Scan from the far end so the nearest requester after 'last' is the final (winning) assignment.
   always_comb begin
      int idx;
      grant       = last;
      grant_valid = 1'b0;
      idx         = 0;
      for (int k = NCH; k >= 1; k--) begin
         idx = (int'(last) + k) % NCH;
         if (req[idx]) begin
            grant       = IW'(idx);
            grant_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else if (en)
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_valid) state_next = ADD;
         ADD:     state_next = WB;
         WB:      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      ack  = '0;
      if (state == WB && en)
         ack[gsel] = 1'b1;
   end

   assign sum_next = acc[gsel] + operand;

`ifdef INTEG_SCHED_SAT_EN
   logic           result_ovf;
   logic [NCH-1:0] sat_r;

   // On overflow both operands share a sign, so the operand sign picks the clamp direction.
   always_comb begin
      wb_value = result;
      if (result_ovf)
         wb_value = operand[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
   end

   assign sat = sat_r;
`else
   assign wb_value = result;
   assign sat      = '0;
`endif

   // Clear is applied after the WB write so it wins on a collision with the same channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last    <= IW'(NCH - 1);
         gsel    <= '0;
         operand <= '0;
         result  <= '0;
         for (int i = 0; i < NCH; i++)
            acc[i] <= '0;
`ifdef INTEG_SCHED_SAT_EN
         result_ovf <= 1'b0;
         sat_r      <= '0;
`endif
      end else if (en) begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  gsel    <= grant;
                  operand <= data[grant*W +: W];
               end
            end
            ADD: begin
               result <= sum_next;
`ifdef INTEG_SCHED_SAT_EN
               result_ovf <= (acc[gsel][W-1] == operand[W-1]) && (sum_next[W-1] != operand[W-1]);
`endif
            end
            WB: begin
               acc[gsel] <= wb_value;
               last      <= gsel;
`ifdef INTEG_SCHED_SAT_EN
               if (result_ovf)
                  sat_r[gsel] <= 1'b1;
`endif
            end
            default: ;
         endcase
         for (int i = 0; i < NCH; i++) begin
            if (clear[i]) begin
               acc[i] <= '0;
`ifdef INTEG_SCHED_SAT_EN
               sat_r[i] <= 1'b0;
`endif
            end
         end
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_pack
      assign sum[i*W +: W] = acc[i];
   end

endmodule

// File: tb/tb_integ_sched.sv
// Self-checking bench for integ_sched: operation-level model compared every cycle plus directed literal checks.
// Define INTEG_SCHED_SAT_EN for both bench and RTL to exercise the saturating build.
module tb_integ_sched;

   localparam int NCH = 3;
   localparam int W   = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [NCH-1:0]   req;
   logic [NCH*W-1:0] data;
   logic [NCH-1:0]   clear;
   logic [NCH-1:0]   ack;
   logic [NCH*W-1:0] sum;
   logic [NCH-1:0]   sat;
   logic             busy;

   int checks   = 0;
   int failures = 0;
   bit cmp_on   = 1'b0;

   int     m_sum [NCH];
   bit     m_sat [NCH];
   bit     m_busy;
   int     m_phase;
   int     m_ch;
   int     m_last;
   int     m_op;
   longint m_res;

   integ_sched #(.NCH(NCH), .W(W)) dut (
      .clk(clk), .rst(rst), .en(en), .req(req), .data(data), .clear(clear),
      .ack(ack), .sum(sum), .sat(sat), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Operation-level model: one outstanding op, result = old sum + operand in exact integer arithmetic.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            m_sum[i] = 0;
            m_sat[i] = 1'b0;
         end
         m_busy  = 1'b0;
         m_phase = 0;
         m_ch    = 0;
         m_last  = NCH - 1;
      end else if (en) begin
         if (!m_busy) begin
            for (int k = 1; k <= NCH; k++) begin
               int c;
               c = (m_last + k) % NCH;
               if (req[c]) begin
                  m_busy  = 1'b1;
                  m_phase = 1;
                  m_ch    = c;
                  m_op    = int'(data[c*W +: W]);
                  break;
               end
            end
         end else if (m_phase == 1) begin
            m_res   = longint'(m_sum[m_ch]) + longint'(m_op);
            m_phase = 2;
         end else begin
`ifdef INTEG_SCHED_SAT_EN
            if (m_res > 64'sd2147483647) begin
               m_sum[m_ch] = 32'h7FFFFFFF;
               m_sat[m_ch] = 1'b1;
            end else if (m_res < -64'sd2147483648) begin
               m_sum[m_ch] = int'(32'h80000000);
               m_sat[m_ch] = 1'b1;
            end else begin
               m_sum[m_ch] = int'(m_res);
            end
`else
            m_sum[m_ch] = int'(m_res);
`endif
            m_last  = m_ch;
            m_busy  = 1'b0;
            m_phase = 0;
         end
         for (int i = 0; i < NCH; i++) begin
            if (clear[i]) begin
               m_sum[i] = 0;
               m_sat[i] = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         check_output("ack", 32'(ack), (m_busy && m_phase == 2 && en) ? (32'd1 << m_ch) : 32'd0);
         check_output("busy", 32'(busy), 32'(m_busy));
         for (int i = 0; i < NCH; i++) begin
            check_output($sformatf("sum%0d", i), sum[i*W +: W], 32'(m_sum[i]));
            check_output($sformatf("sat%0d", i), 32'(sat[i]), 32'(m_sat[i]));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic apply_stimulus(input logic [NCH-1:0] r, input logic [NCH-1:0] c);
      req   = r;
      clear = c;
   endtask

   task automatic wait_ack(output logic [NCH-1:0] seen, output int n);
      n    = 0;
      seen = '0;
      while (seen == '0 && n < 12) begin
         tick(1);
         n++;
         seen = ack;
      end
      if (seen == '0) begin
         checks++;
         failures++;
         $display("[TB] FAIL ack_timeout: got no ack after %0d cycles, required an ack", n);
      end
   endtask

   task automatic do_op(input int ch, input logic [31:0] v);
      logic [NCH-1:0] seen;
      int n;
      data[ch*W +: W] = v;
      apply_stimulus(NCH'(1) << ch, '0);
      wait_ack(seen, n);
      check_output("op_ack", 32'(seen), 32'd1 << ch);
      check_output("op_latency", 32'(n), 32'd2);
      apply_stimulus('0, '0);
      tick(1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [NCH-1:0] seen;
      logic [31:0]    exp_sum1;
      logic [31:0]    exp_sat1;
      int             n;

      rst   = 1'b1;
      en    = 1'b0;
      req   = '0;
      clear = '0;
      data  = '0;
      tick(2);
      for (int i = 0; i < NCH; i++)
         check_output("rst_sum", sum[i*W +: W], 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_ack", 32'(ack), 32'd0);
      check_output("rst_sat", 32'(sat), 32'd0);
      cmp_on = 1'b1;
      rst    = 1'b0;
      en     = 1'b1;
      tick(1);

      // Basic add then a negative operand
      do_op(0, 32'd5);
      check_output("basic_sum0", sum[0 +: 32], 32'd5);
      do_op(0, 32'hFFFFFFF9);
      check_output("basic_sum0_neg", sum[0 +: 32], 32'hFFFFFFFE);

      // All channels requesting continuously
      do_reset();
      data = {32'd3, 32'd2, 32'd1};
      apply_stimulus('1, '0);
      for (int j = 0; j < 6; j++) begin
         wait_ack(seen, n);
         check_output($sformatf("rr_order%0d", j), 32'(seen), 32'd1 << (j % 3));
         check_output($sformatf("rr_gap%0d", j), 32'(n), (j == 0) ? 32'd2 : 32'd3);
      end
      apply_stimulus('0, '0);
      tick(1);
      check_output("rr_sum0", sum[0 +: 32], 32'd2);
      check_output("rr_sum1", sum[32 +: 32], 32'd4);
      check_output("rr_sum2", sum[64 +: 32], 32'd6);

      // Positive overflow on channel 1
      apply_stimulus('0, 3'b010);
      tick(1);
      apply_stimulus('0, '0);
      do_op(1, 32'h7FFFFFF0);
      do_op(1, 32'h00000020);
`ifdef INTEG_SCHED_SAT_EN
      exp_sum1 = 32'h7FFFFFFF;
      exp_sat1 = 32'd1;
`else
      exp_sum1 = 32'h80000010;
      exp_sat1 = 32'd0;
`endif
      check_output("ovf_sum1", sum[32 +: 32], exp_sum1);
      check_output("ovf_sat1", 32'(sat[1]), exp_sat1);

      // Clear colliding with the WB of the same channel
      data[64 +: 32] = 32'd9;
      apply_stimulus(3'b100, '0);
      wait_ack(seen, n);
      check_output("clr_ack", 32'(seen), 32'b100);
      apply_stimulus('0, 3'b100);
      tick(1);
      apply_stimulus('0, '0);
      check_output("clr_sum2", sum[64 +: 32], 32'd0);
      check_output("clr_sum0", sum[0 +: 32], 32'd2);
      check_output("clr_sum1", sum[32 +: 32], exp_sum1);

      // Enable dropped for 4 cycles during ADD; clear while disabled is ignored
      data[0 +: 32] = 32'd10;
      apply_stimulus(3'b001, '0);
      tick(1);
      check_output("stall_busy", 32'(busy), 32'd1);
      en = 1'b0;
      for (int j = 0; j < 4; j++) begin
         clear = (j == 1) ? 3'b010 : 3'b000;
         tick(1);
         check_output("stall_ack", 32'(ack), 32'd0);
         check_output("stall_held", 32'(busy), 32'd1);
      end
      en = 1'b1;
      tick(1);
      check_output("stall_resume_ack", 32'(ack), 32'b001);
      apply_stimulus('0, '0);
      tick(1);
      check_output("stall_sum0", sum[0 +: 32], 32'd12);
      check_output("stall_sum1", sum[32 +: 32], exp_sum1);

      // Reset in the middle of a channel-1 operation
      data[32 +: 32] = 32'd5;
      apply_stimulus(3'b010, '0);
      tick(1);
      check_output("mid_busy", 32'(busy), 32'd1);
      #1;
      rst = 1'b1;
      apply_stimulus('0, '0);
      #1;
      check_output("mid_rst_busy", 32'(busy), 32'd0);
      check_output("mid_rst_ack", 32'(ack), 32'd0);
      check_output("mid_rst_sum", sum[95:64] | sum[63:32] | sum[31:0], 32'd0);
      tick(1);
      rst = 1'b0;
      tick(2);
      check_output("post_rst_ack", 32'(ack), 32'd0);
      data = {32'd3, 32'd2, 32'd1};
      apply_stimulus('1, '0);
      wait_ack(seen, n);
      check_output("post_rst_first", 32'(seen), 32'b001);
      apply_stimulus('0, '0);
      tick(1);
      check_output("post_rst_sum0", sum[0 +: 32], 32'd1);

      // Negative overflow on channel 0, then clear drops the flag
      do_op(0, 32'h80000000);
      check_output("neg_step_sum0", sum[0 +: 32], 32'h80000001);
      do_op(0, 32'hFFFFFFFE);
`ifdef INTEG_SCHED_SAT_EN
      check_output("neg_ovf_sum0", sum[0 +: 32], 32'h80000000);
      check_output("neg_ovf_sat0", 32'(sat[0]), 32'd1);
`else
      check_output("neg_ovf_sum0", sum[0 +: 32], 32'h7FFFFFFF);
      check_output("neg_ovf_sat0", 32'(sat[0]), 32'd0);
`endif
      apply_stimulus('0, 3'b001);
      tick(1);
      apply_stimulus('0, '0);
      check_output("final_clr_sum0", sum[0 +: 32], 32'd0);
      check_output("final_clr_sat0", 32'(sat[0]), 32'd0);

      tick(2);
      cmp_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
